// File: rtl/dma_rd_arb_pkg.sv
// Shared types and constants for the two-port DMA read arbiter.
// The optional REQ-state timeout is compiled in with DMA_RD_ARB_TIMEOUT_EN.
package dma_rd_arb_pkg;

   // Arbiter FSM encoding
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_e;

   // Requester identities; also the encoding of the round-robin pointer
   typedef enum logic {
      OWN_IC   = 1'b0,
      OWN_WAVE = 1'b1
   } owner_e;

   // Byte offset bits inside one 128-bit cache line
   localparam int unsigned LINE_OFF_W = 4;

   // The requester that did not own the last transaction
   function automatic owner_e other_owner(input owner_e own);
      return (own == OWN_IC) ? OWN_WAVE : OWN_IC;
   endfunction

endpackage

// File: rtl/dma_rd_arb_rr_arb2.sv
// Two-way round-robin picker: a lone requester always wins, and when both
// request the pointer names the winner. Purely combinational.
// Timeout option DMA_RD_ARB_TIMEOUT_EN does not affect this block.
module rr_arb2
   import dma_rd_arb_pkg::*;
(
   input  logic   req0_i,
   input  logic   req1_i,
   input  owner_e ptr_i,
   output owner_e gnt_id_o,
   output logic   gnt_valid_o
);

   // Pick the winner from the request pair and the pointer
   always_comb begin
      // NOTE: every output gets a default first so no path through the
      // if/else leaves it unassigned, which would infer a latch.
      gnt_id_o    = OWN_IC;
      gnt_valid_o = req0_i | req1_i;
      if (req0_i && req1_i) begin
         gnt_id_o = ptr_i;
      end else if (req1_i) begin
         gnt_id_o = OWN_WAVE;
      end
   end

endmodule

// File: rtl/dma_rd_arb.sv
// dma_rd_arb: shares the single 128-bit DRAM DMA read port between icache
// line refills (port 0) and waveform-buffer prefetch (port 1). One read is
// outstanding at a time and grants alternate round-robin.
// Build option: define DMA_RD_ARB_TIMEOUT_EN to abort a REQ that has waited
// to_cyc cycles for dma_ack; the owner then gets an ack with zero data and err.
module dma_rd_arb
   import dma_rd_arb_pkg::*;
#(
   parameter int unsigned aw     = 33,
   parameter int unsigned dw     = 128,
   parameter int unsigned to_cyc = 1024,
   parameter int unsigned to_w   = 11
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          m0_valid,
   input  logic [aw-1:0] m0_addr,
   output logic          m0_ack,
   output logic [dw-1:0] m0_data,
   input  logic          m1_valid,
   input  logic [aw-1:0] m1_addr,
   output logic          m1_ack,
   output logic [dw-1:0] m1_data,
   output logic [aw-1:0] dma_addr,
   output logic          dma_valid,
   input  logic          dma_ack,
   input  logic [dw-1:0] dma_data,
   output logic          busy,
   output logic          err
);

   // Clears the byte offset so the DMA engine always sees a line address
   localparam logic [aw-1:0] LINE_MASK = {{(aw-LINE_OFF_W){1'b1}}, {LINE_OFF_W{1'b0}}};

   state_e        state_q, state_d;
   owner_e        owner_q, owner_d;
   owner_e        ptr_q, ptr_d;
   logic [aw-1:0] addr_q, addr_d;
   logic          ack0_q, ack0_d;
   logic          ack1_q, ack1_d;
   logic [dw-1:0] data0_q, data0_d;
   logic [dw-1:0] data1_q, data1_d;
   logic          err_q, err_d;

   owner_e        gnt_id;
   logic          gnt_valid;
   logic [aw-1:0] sel_addr;
   logic          timeout_hit;
   logic          req_done;
   logic [dw-1:0] resp_data;

   rr_arb2 u_rr_arb2 (
      .req0_i      (m0_valid),
      .req1_i      (m1_valid),
      .ptr_i       (ptr_q),
      .gnt_id_o    (gnt_id),
      .gnt_valid_o (gnt_valid)
   );

   assign sel_addr = (gnt_id == OWN_WAVE) ? m1_addr : m0_addr;

`ifdef DMA_RD_ARB_TIMEOUT_EN
   localparam logic [to_w-1:0] TO_LAST = to_w'(to_cyc - 1);

   logic [to_w-1:0] to_cnt_q, to_cnt_d;

   // Count REQ cycles; restarts from zero whenever REQ is entered, saturates
   always_comb begin
      to_cnt_d = to_cnt_q;
      if (state_q != REQ) begin
         to_cnt_d = '0;
      end else if (to_cnt_q != '1) begin
         to_cnt_d = to_cnt_q + 1'b1;
      end
   end

   // Timeout counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt_q <= '0;
      end else begin
         to_cnt_q <= to_cnt_d;
      end
   end

   // The to_cyc-th REQ cycle without an ack aborts the read
   assign timeout_hit = (state_q == REQ) && (to_cnt_q == TO_LAST);
`else
   logic cfg_unused;

   // Without the timeout REQ waits for dma_ack indefinitely
   assign timeout_hit = 1'b0;
   assign cfg_unused  = (to_cyc < (32'd1 << to_w));
`endif

   // A REQ ends on dma_ack, or on timeout; dma_ack wins a tie
   assign req_done  = dma_ack | timeout_hit;
   assign resp_data = dma_ack ? dma_data : '0;

   // Next-state and next-output logic of the arbiter FSM
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      addr_d  = addr_q;
      ack0_d  = 1'b0;
      ack1_d  = 1'b0;
      data0_d = data0_q;
      data1_d = data1_q;
      err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            // dma_ack is meaningless here, so a late one is ignored
            if (gnt_valid) begin
               owner_d = gnt_id;
               addr_d  = sel_addr & LINE_MASK;
               state_d = REQ;
            end
         end
         REQ: begin
            if (req_done) begin
               state_d = RESP;
               err_d   = ~dma_ack;
               if (owner_q == OWN_IC) begin
                  ack0_d  = 1'b1;
                  data0_d = resp_data;
               end else begin
                  ack1_d  = 1'b1;
                  data1_d = resp_data;
               end
            end
         end
         RESP: begin
            // Hand priority to the other port so neither waits more than one read
            ptr_d   = other_owner(owner_q);
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, latched request and registered response outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         owner_q <= OWN_IC;
         ptr_q   <= OWN_IC;
         addr_q  <= '0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         data0_q <= '0;
         data1_q <= '0;
         err_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, independent of statement order.
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         addr_q  <= addr_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
         data0_q <= data0_d;
         data1_q <= data1_d;
         err_q   <= err_d;
      end
   end

   assign dma_valid = (state_q == REQ);
   assign dma_addr  = addr_q;
   assign busy      = (state_q != IDLE);
   assign m0_ack    = ack0_q;
   assign m1_ack    = ack1_q;
   assign m0_data   = data0_q;
   assign m1_data   = data1_q;
   assign err       = err_q;

endmodule

// File: tb/tb_dma_rd_arb.sv
// Self-checking bench for dma_rd_arb. Expected reads are queued when a
// request is driven and compared when the owner's ack appears.
// Timeout checks follow DMA_RD_ARB_TIMEOUT_EN (to_cyc is set to 16).
module tb_dma_rd_arb;

   typedef struct {
      logic         port;
      logic [32:0]  addr;
      logic [127:0] data;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic         m0_valid, m1_valid;
   logic [32:0]  m0_addr, m1_addr;
   logic         m0_ack, m1_ack;
   logic [127:0] m0_data, m1_data;
   logic [32:0]  dma_addr;
   logic         dma_valid;
   logic         dma_ack;
   logic [127:0] dma_data;
   logic         busy;
   logic         err;

   int   n_pass;
   int   n_total;
   int   cyc;
   exp_t exp_q[$];

   dma_rd_arb #(
      .aw     (33),
      .dw     (128),
      .to_cyc (16),
      .to_w   (5)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .m0_valid  (m0_valid),
      .m0_addr   (m0_addr),
      .m0_ack    (m0_ack),
      .m0_data   (m0_data),
      .m1_valid  (m1_valid),
      .m1_addr   (m1_addr),
      .m1_ack    (m1_ack),
      .m1_data   (m1_data),
      .dma_addr  (dma_addr),
      .dma_valid (dma_valid),
      .dma_ack   (dma_ack),
      .dma_data  (dma_data),
      .busy      (busy),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
      $fatal(1, "watchdog");
   end

   function automatic logic [32:0] line_of(input logic [32:0] a);
      return {a[32:4], 4'h0};
   endfunction

   function automatic exp_t mk(input logic p, input logic [32:0] a, input logic [127:0] d);
      exp_t e;
      e.port = p;
      e.addr = line_of(a);
      e.data = d;
      return e;
   endfunction

   task automatic do_reset(input logic v0, input logic v1);
      rst_n    = 1'b0;
      m0_valid = v0;
      m1_valid = v1;
      dma_ack  = 1'b0;
      dma_data = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Acts as the DMA engine for the transaction at the head of the scoreboard
   task automatic serve(input int lat, input bit drop, input string tag, output int waited);
      exp_t         e;
      logic         own_ack, oth_ack;
      logic [127:0] own_data;
      waited = 0;
      while (dma_valid !== 1'b1 && waited < 64) begin
         @(negedge clk);
         waited++;
      end
      n_total++;
      if (dma_valid !== 1'b1) $display("FAIL %s dma_valid: got %b want 1", tag, dma_valid);
      else n_pass++;
      if (exp_q.size() == 0) begin
         n_total++;
         $display("FAIL %s scoreboard: empty queue", tag);
         return;
      end
      e = exp_q[0];
      n_total++;
      if (dma_addr !== e.addr) $display("FAIL %s dma_addr: got %h want %h", tag, dma_addr, e.addr);
      else n_pass++;
      repeat (lat) @(negedge clk);
      n_total++;
      if (dma_valid !== 1'b1 || m0_ack !== 1'b0 || m1_ack !== 1'b0)
         $display("FAIL %s held_req: valid=%b acks=%b%b want 1 00", tag, dma_valid, m0_ack, m1_ack);
      else n_pass++;
      dma_ack  = 1'b1;
      dma_data = e.data;
      @(negedge clk);
      dma_ack  = 1'b0;
      dma_data = ~e.data;
      e        = exp_q.pop_front();
      own_ack  = e.port ? m1_ack : m0_ack;
      oth_ack  = e.port ? m0_ack : m1_ack;
      own_data = e.port ? m1_data : m0_data;
      n_total++;
      if (own_ack !== 1'b1 || oth_ack !== 1'b0)
         $display("FAIL %s ack: port%0d got %b other %b want 1 0", tag, e.port, own_ack, oth_ack);
      else n_pass++;
      n_total++;
      if (own_data !== e.data) $display("FAIL %s data: got %h want %h", tag, own_data, e.data);
      else n_pass++;
      n_total++;
      if (dma_valid !== 1'b0 || err !== 1'b0)
         $display("FAIL %s resp: dma_valid=%b err=%b want 0 0", tag, dma_valid, err);
      else n_pass++;
      if (drop) begin
         if (e.port) m1_valid = 1'b0;
         else m0_valid = 1'b0;
      end
      @(negedge clk);
      own_data = e.port ? m1_data : m0_data;
      n_total++;
      if (m0_ack !== 1'b0 || m1_ack !== 1'b0 || busy !== 1'b0 || own_data !== e.data)
         $display("FAIL %s after: acks=%b%b busy=%b data=%h want 00 0 %h",
                  tag, m0_ack, m1_ack, busy, own_data, e.data);
      else n_pass++;
   endtask

   task automatic test_reset();
      do_reset(1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      n_total++;
      if ({m0_ack, m1_ack, dma_valid, busy, err} !== 5'b0 || m0_data !== '0 || m1_data !== '0 || dma_addr !== '0)
         $display("FAIL reset_values: acks=%b%b dma_valid=%b busy=%b err=%b want all 0",
                  m0_ack, m1_ack, dma_valid, busy, err);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      int w;
      m0_addr  = 33'h2013;
      m0_valid = 1'b1;
      exp_q.push_back(mk(1'b0, 33'h2013, 128'h5A));
      serve(2, 1'b1, "single", w);
      n_total++;
      if (w !== 1) $display("FAIL single_latency: dma_valid after %0d cycles want 1", w);
      else n_pass++;
   endtask

   task automatic test_contention();
      int w;
      m0_addr = 33'h100;
      m1_addr = 33'h208;
      do_reset(1'b1, 1'b1);
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(mk(i[0], i[0] ? 33'h208 : 33'h100, {32'hC0DE0000 | i, 64'h0, 32'(i)}));
      end
      for (int i = 0; i < 4; i++) begin
         serve(1, i >= 2, "contention", w);
         n_total++;
         if (w !== 1) $display("FAIL contention_gap: grant %0d after %0d cycles want 1", i, w);
         else n_pass++;
      end
   endtask

   task automatic test_single_m1();
      int w;
      m1_addr  = 33'h1_FFFF_FFFF;
      m1_valid = 1'b1;
      exp_q.push_back(mk(1'b1, 33'h1_FFFF_FFFF, 128'hFEED_0000_0000_0000_0000_0000_0000_BEEF));
      serve(3, 1'b1, "single_m1", w);
   endtask

   task automatic test_zero_wait();
      int w, c0;
      m0_addr  = 33'h40;
      m0_valid = 1'b1;
      c0       = cyc;
      exp_q.push_back(mk(1'b0, 33'h40, 128'h1234));
      // serve ends one cycle after the ack cycle
      serve(0, 1'b1, "zero_wait", w);
      n_total++;
      if (cyc - c0 !== 3) $display("FAIL zero_wait_latency: %0d cycles to idle want 3", cyc - c0);
      else n_pass++;
   endtask

   task automatic test_timeout();
      int w;
`ifdef DMA_RD_ARB_TIMEOUT_EN
      int n;
      m1_addr  = 33'h3007;
      m1_valid = 1'b1;
      n        = 0;
      w        = 0;
      while (dma_valid !== 1'b1 && w < 64) begin
         @(negedge clk);
         w++;
      end
      while (dma_valid === 1'b1 && n < 200) begin
         n++;
         @(negedge clk);
      end
      n_total++;
      if (n !== 16) $display("FAIL timeout_len: dma_valid high %0d cycles want 16", n);
      else n_pass++;
      n_total++;
      if (m1_ack !== 1'b1 || m0_ack !== 1'b0 || m1_data !== '0 || err !== 1'b1)
         $display("FAIL timeout_resp: m1_ack=%b m0_ack=%b m1_data=%h err=%b want 1 0 0 1",
                  m1_ack, m0_ack, m1_data, err);
      else n_pass++;
      m1_valid = 1'b0;
      @(negedge clk);
      n_total++;
      if (err !== 1'b0 || m1_ack !== 1'b0 || busy !== 1'b0)
         $display("FAIL timeout_after: err=%b m1_ack=%b busy=%b want 0 0 0", err, m1_ack, busy);
      else n_pass++;
      // An ack in the same cycle as the timeout wins with no err
      m1_valid = 1'b1;
      exp_q.push_back(mk(1'b1, 33'h3007, 128'h77));
      serve(15, 1'b1, "timeout_tie", w);
`else
      int ok;
      m0_addr  = 33'h5555;
      m0_valid = 1'b1;
      exp_q.push_back(mk(1'b0, 33'h5555, 128'h99));
      w = 0;
      while (dma_valid !== 1'b1 && w < 64) begin
         @(negedge clk);
         w++;
      end
      ok = 0;
      for (int i = 0; i < 120; i++) begin
         if (dma_valid === 1'b1 && err === 1'b0 && m0_ack === 1'b0) ok++;
         @(negedge clk);
      end
      n_total++;
      if (ok !== 120) $display("FAIL no_timeout: waiting cycles ok %0d want 120", ok);
      else n_pass++;
      serve(0, 1'b1, "no_timeout_ack", w);
`endif
   endtask

   task automatic test_refill_sweep();
      int w;
      for (int i = 0; i < 512; i++) begin
         m0_addr  = 33'(i * 16);
         m0_valid = 1'b1;
         exp_q.push_back(mk(1'b0, 33'(i * 16), 128'(i)));
         serve(2, 1'b1, "sweep", w);
      end
      n_total++;
      if (exp_q.size() !== 0) $display("FAIL sweep_drain: %0d left want 0", exp_q.size());
      else n_pass++;
   endtask

   task automatic test_reset_mid_req();
      int w, bad;
      m0_addr  = 33'h7777;
      m0_valid = 1'b1;
      w        = 0;
      while (dma_valid !== 1'b1 && w < 64) begin
         @(negedge clk);
         w++;
      end
      rst_n    = 1'b0;
      m0_valid = 1'b0;
      #1;
      n_total++;
      if ({m0_ack, m1_ack, dma_valid, busy, err} !== 5'b0 || m0_data !== '0 || dma_addr !== '0)
         $display("FAIL reset_mid_req: acks=%b%b dma_valid=%b busy=%b dma_addr=%h want all 0",
                  m0_ack, m1_ack, dma_valid, busy, dma_addr);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      dma_ack  = 1'b1;
      dma_data = 128'hBAD;
      @(negedge clk);
      dma_ack = 1'b0;
      bad     = 0;
      for (int i = 0; i < 4; i++) begin
         if ({m0_ack, m1_ack, dma_valid, busy, err} !== 5'b0 || m0_data !== '0) bad++;
         @(negedge clk);
      end
      n_total++;
      if (bad !== 0) $display("FAIL late_dma_ack: %0d bad cycles want 0", bad);
      else n_pass++;
   endtask

   initial begin
      n_pass   = 0;
      n_total  = 0;
      cyc      = 0;
      m0_addr  = '0;
      m1_addr  = '0;
      m0_valid = 1'b0;
      m1_valid = 1'b0;
      dma_ack  = 1'b0;
      dma_data = '0;
      rst_n    = 1'b0;
      @(negedge clk);
      test_reset();
      test_single();
      test_contention();
      test_single_m1();
      test_zero_wait();
      test_timeout();
      test_refill_sweep();
      test_reset_mid_req();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
